data_ram_bw: RTL and testbench
==============================

Name: data_ram_bw

Overview:
Parametrised single-port synchronous data RAM with per-byte write enables, selectable read-during-write mode and selectable read latency (1 or 2 cycles). A valid strobe accompanies every returned word. Sits behind the MIPS memory stage as the data memory and replaces the fixed-size, fixed-latency RAM used so far.

Parameters:
DATA_W, 32, word width in bits; multiple of 8
DEPTH, 1024, number of words; power of two
ADDR_W, 32, width of the word-address port
READ_LATENCY, 1, cycles from the accepting edge to rdata/rvalid; legal values 1 or 2
WRITE_FIRST, 0, read-during-write result: 0 returns the old word, 1 returns the merged new word

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  access request, sampled on the rising edge
we  input  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i]
addr  input  ADDR_W  word address, not a byte address
wdata  input  DATA_W  write data
rdata  output  DATA_W  read data
rvalid  output  1  rdata holds the result of an accepted access
err  output  1  out-of-range flag; present only with DATA_RAM_OOR_EN

Behaviour:
- Index: idx = addr[log2(DEPTH)-1:0].
- Access accepted on a rising edge when en=1 and rst=0. No backpressure: one access per cycle, back-to-back allowed.
- Write: each byte i with we[i]=1 is updated at the accepting edge. Bytes with we[i]=0 are unchanged. we=0 means a pure read.
- Every accepted access, read or write, returns a word:
  - WRITE_FIRST=0: the pre-write word.
  - WRITE_FIRST=1: the merged word (new bytes where we=1, old bytes elsewhere).
- Latency 1: rdata/rvalid update at the accepting edge.
- Latency 2: an extra output register delays rdata/rvalid by one further cycle. Pipeline slots advance every cycle.
- rvalid is 1 exactly READ_LATENCY cycles after each accepted access, otherwise 0.
- rdata holds its last value when rvalid=0. It is never forced to zero except by reset.
- Read of an address written in the previous cycle returns the new data (no stale hazard).
- Reset (async assert, sync release):
  - rdata=0, rvalid=0, err=0; all pipeline stages cleared.
  - An in-flight result is dropped.
  - Memory contents are NOT reset.
  - Writes are suppressed while rst=1, including an access coincident with reset assertion.
- Upper address bits above the index are ignored without the macro, so addresses alias modulo DEPTH.
- Contents after configuration are undefined; the bench preloads memory via a write sequence.

Optional Feature:
Macro DATA_RAM_OOR_EN.
- Defined:
  - An access with addr >= DEPTH is out-of-range.
  - The write is suppressed.
  - The returned rdata is 0 and err=1, both aligned with rvalid at the same latency.
  - err=0 for in-range accesses and when rvalid=0.
- Undefined:
  - The err port does not exist.
  - Out-of-range addresses alias.

Decomposition:
- Package ram_pkg holds:
  - constants RD_FIRST=0 and WR_FIRST=1;
  - function clog2;
  - function byte_merge(old, new, we), used by both the write path and the write-first return path.
- One sub-module, ram_out_pipe: a 1- or 2-stage register for {rdata, rvalid, err} with async reset, selected by READ_LATENCY.
- The storage array and write logic stay in data_ram_bw.

Test Plan:
- Reset then read: assert rst, release, read addr 1 -> rvalid=0 during reset; after the read, rvalid=1 exactly READ_LATENCY cycles later with rdata equal to the preloaded word.
- Partial write: mem[3]=32'h11223344, write we=4'b0101 wdata=32'hAABBCCDD -> WRITE_FIRST=0 returns 32'h11223344, WRITE_FIRST=1 returns 32'h11BB33DD; a following read of 3 returns 32'h11BB33DD.
- Back-to-back: write 32'hDEADBEEF to addr 5 at cycle N, read 5 at N+1 -> 32'hDEADBEEF; reads of addr 1,2,3,4 on consecutive cycles -> four consecutive rvalid pulses, in order, for both latencies.
- Idle hold: read addr 2 (32'h0000_0002 preloaded), then en=0 for 3 cycles -> rvalid=0 and rdata stays 32'h0000_0002.
- Reset mid-operation (READ_LATENCY=2): read issued, rst asserted one cycle later -> no rvalid pulse; a write coincident with rst leaves memory unchanged.
- Out-of-range: DEPTH=1024, write addr 1024 -> macro defined: err=1, rdata=0, mem[0] unchanged; macro undefined: mem[0] written (alias).

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and helpers for the byte-writable data RAM (data_ram_bw).
package ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // One byte lane of a masked write: the new byte replaces the old only where enabled.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       we);
    return we ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_out_pipe.sv
// Output register for the RAM return path: one or two stages of {payload, valid}.
module ram_out_pipe #(
  parameter int W       = 33,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         s1_valid;
  logic [W-1:0] s1_data;

  // Payload only moves with a valid word so the output holds its last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  generate
    if (LATENCY == 2) begin : g_two
      logic         s2_valid;
      logic [W-1:0] s2_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign out_valid = s2_valid;
      assign out_data  = s2_data;
    end else begin : g_one
      assign out_valid = s1_valid;
      assign out_data  = s1_data;
    end
  endgenerate

endmodule

// File: rtl/data_ram_bw.sv
// Single-port data RAM with byte enables, selectable read-during-write and 1/2-cycle latency.
// Optional out-of-range detection with err port: define DATA_RAM_OOR_EN.
module data_ram_bw
  import ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
`ifdef DATA_RAM_OOR_EN
  ,
  output logic                err
`endif
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_hi;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] ret_word;
  logic              oor;
  logic              wr_en;

  assign idx      = addr[IDX_W-1:0];
  assign addr_hi  = addr >> IDX_W;
  assign old_word = mem[idx];

  generate
    for (genvar b = 0; b < NB; b++) begin : g_lane
      assign merged[8*b +: 8] = byte_merge(old_word[8*b +: 8], wdata[8*b +: 8], we[b]);
    end
  endgenerate

`ifdef DATA_RAM_OOR_EN
  assign oor = |addr_hi;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_hi;
  assign oor            = 1'b0;
`endif

  // Writes are gated by rst too, so an access landing on reset assertion cannot corrupt memory.
  assign wr_en = en && !rst && !oor && (|we);

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= merged;
  end

  assign ret_word = (WRITE_FIRST == RD_FIRST) ? old_word : merged;

`ifdef DATA_RAM_OOR_EN
  localparam int PW = DATA_W + 1;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;

  assign pipe_in = {oor, (oor ? {DATA_W{1'b0}} : ret_word)};
  assign rdata   = pipe_out[DATA_W-1:0];
  // The stored flag stays with the held word, so it is qualified by rvalid at the port.
  assign err     = pipe_out[DATA_W] & rvalid;
`else
  localparam int PW = DATA_W;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;

  assign pipe_in = ret_word;
  assign rdata   = pipe_out;
`endif

  ram_out_pipe #(
    .W       (PW),
    .LATENCY (READ_LATENCY)
  ) u_out_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (en),
    .in_data   (pipe_in),
    .out_valid (rvalid),
    .out_data  (pipe_out)
  );

endmodule

// File: tb/tb_data_ram_bw.sv
// Bench for data_ram_bw: latency-1/read-first and latency-2/write-first instances share stimulus.
module tb_data_ram_bw;

  localparam int DEPTH = 1024;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
`ifdef DATA_RAM_OOR_EN
  logic        err_a, err_b;
`endif

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  logic [31:0] mmem [int];
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] held_a = 32'h0;
  logic [31:0] held_b = 32'h0;
  bit          known_a = 1'b1;
  bit          known_b = 1'b1;

  always #5 clk = ~clk;

  data_ram_bw #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LATENCY(1), .WRITE_FIRST(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .rvalid(rvalid_a)
`ifdef DATA_RAM_OOR_EN
    , .err(err_a)
`endif
  );

  data_ram_bw #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .READ_LATENCY(2), .WRITE_FIRST(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .rvalid(rvalid_b)
`ifdef DATA_RAM_OOR_EN
    , .err(err_b)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] w,
                               input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; en = e; we = w; addr = a; wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Memory model keyed by word index; a missing key means the word was never fully written.
  always @(posedge clk) begin : model
    int          idx;
    bit          oor, known, new_known;
    logic [31:0] old, merged;
    exp_t        e;
    cyc++;
    if (!rst && en) begin
      idx = int'(addr % DEPTH);
      oor = 1'b0;
`ifdef DATA_RAM_OOR_EN
      oor = (addr >= DEPTH);
`endif
      known = mmem.exists(idx);
      old   = known ? mmem[idx] : 32'h0;
      for (int b = 0; b < 4; b++) merged[8*b +: 8] = we[b] ? wdata[8*b +: 8] : old[8*b +: 8];
      new_known = known || (we == 4'hF);
      if (!oor && we != 4'h0) begin
        if (new_known) mmem[idx] = merged;
        else mmem.delete(idx);
      end
      e.due   = cyc;
      e.data  = oor ? 32'h0 : old;
      e.known = oor || known;
      e.err   = oor;
      q_a.push_back(e);
      e.due   = cyc + 1;
      e.data  = oor ? 32'h0 : merged;
      e.known = oor || new_known;
      q_b.push_back(e);
    end
  end

  always @(posedge rst) begin
    q_a.delete();
    q_b.delete();
    held_a = 32'h0; held_b = 32'h0;
    known_a = 1'b1; known_b = 1'b1;
  end

  always @(negedge clk) begin : compare
    bit va, vb, ea, eb;
    if (chk_on) begin
      va = (q_a.size() > 0) && (q_a[0].due == cyc);
      ea = 1'b0;
      if (va) begin
        held_a = q_a[0].data; known_a = q_a[0].known; ea = q_a[0].err;
        void'(q_a.pop_front());
      end
      vb = (q_b.size() > 0) && (q_b[0].due == cyc);
      eb = 1'b0;
      if (vb) begin
        held_b = q_b[0].data; known_b = q_b[0].known; eb = q_b[0].err;
        void'(q_b.pop_front());
      end
      checkOutput("rvalid_a", {31'b0, rvalid_a}, {31'b0, va});
      checkOutput("rvalid_b", {31'b0, rvalid_b}, {31'b0, vb});
      if (known_a) checkOutput("rdata_a", rdata_a, held_a);
      if (known_b) checkOutput("rdata_b", rdata_b, held_b);
`ifdef DATA_RAM_OOR_EN
      checkOutput("err_a", {31'b0, err_a}, {31'b0, ea});
      checkOutput("err_b", {31'b0, err_b}, {31'b0, eb});
`endif
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Requests during reset must not produce results.
    applyStimulus(1'b1, 1'b1, 4'h0, 32'd1, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0, 32'd1, 32'h0);

    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 4'hF, i, i);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'd3, 32'h11223344);
    idle(3);

    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd1, 32'h0);
    idle(3);
    checkOutput("reset_read_a", rdata_a, 32'h0000_0001);
    checkOutput("reset_read_b", rdata_b, 32'h0000_0001);

    applyStimulus(1'b0, 1'b1, 4'b0101, 32'd3, 32'hAABBCCDD);
    idle(3);
    checkOutput("partial_ret_a", rdata_a, 32'h11223344);
    checkOutput("partial_ret_b", rdata_b, 32'h11BB33DD);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd3, 32'h0);
    idle(3);
    checkOutput("partial_read_a", rdata_a, 32'h11BB33DD);
    checkOutput("partial_read_b", rdata_b, 32'h11BB33DD);

    applyStimulus(1'b0, 1'b1, 4'hF, 32'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd5, 32'h0);
    idle(3);
    checkOutput("raw_a", rdata_a, 32'hDEADBEEF);
    checkOutput("raw_b", rdata_b, 32'hDEADBEEF);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 4'h0, i, 32'h0);
    idle(3);
    checkOutput("b2b_last_a", rdata_a, 32'h0000_0004);
    checkOutput("b2b_last_b", rdata_b, 32'h0000_0004);

    applyStimulus(1'b0, 1'b1, 4'h0, 32'd2, 32'h0);
    idle(3);
    checkOutput("hold_a", rdata_a, 32'h0000_0002);
    checkOutput("hold_b", rdata_b, 32'h0000_0002);

    // Read in flight, then reset with a coincident write that must be dropped.
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd6, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'd6, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd6, 32'h0);
    idle(3);
    checkOutput("rst_write_a", rdata_a, 32'h0000_0006);
    checkOutput("rst_write_b", rdata_b, 32'h0000_0006);

    applyStimulus(1'b0, 1'b1, 4'hF, 32'd1024, 32'h5555AAAA);
    idle(3);
    checkOutput("oor_ret_a", rdata_a, 32'h0000_0000);
`ifdef DATA_RAM_OOR_EN
    checkOutput("oor_ret_b", rdata_b, 32'h0000_0000);
`else
    checkOutput("oor_ret_b", rdata_b, 32'h5555AAAA);
`endif
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd0, 32'h0);
    idle(3);
`ifdef DATA_RAM_OOR_EN
    checkOutput("oor_mem0_a", rdata_a, 32'h0000_0000);
    checkOutput("oor_mem0_b", rdata_b, 32'h0000_0000);
`else
    checkOutput("oor_mem0_a", rdata_a, 32'h5555AAAA);
    checkOutput("oor_mem0_b", rdata_b, 32'h5555AAAA);
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
